// File: rtl/fpu_operand_feeder.sv
// Packs generated sign/exponent/fraction fields into IEEE-754 single operand pairs,
// classifies them and queues them in a show-ahead FIFO that feeds the FPU under test.
module fpu_operand_feeder #(
   parameter int DEPTH        = 4,
   parameter bit FLUSH_DENORM = 1'b0,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sig1,
   input  logic [7:0]                 exp1,
   input  logic [22:0]                fra1,
   input  logic                       sig2,
   input  logic [7:0]                 exp2,
   input  logic [22:0]                fra2,
   input  logic                       cap_en,
   output logic                       cap_ready,
   output logic [31:0]                x1,
   output logic [31:0]                x2,
   output logic [2:0]                 class1,
   output logic [2:0]                 class2,
   output logic                       valid,
   input  logic                       ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic [CNT_W-1:0]           issue_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [2:0] CLS_ZERO   = 3'd0;
   localparam logic [2:0] CLS_DENORM = 3'd1;
   localparam logic [2:0] CLS_INF    = 3'd2;
   localparam logic [2:0] CLS_NAN    = 3'd3;
   localparam logic [2:0] CLS_NORMAL = 3'd4;

   function automatic logic [2:0] classify(input logic [7:0] e, input logic [22:0] f);
      logic [2:0] c;
      if (e == 8'd0)
         c = (f == 23'd0) ? CLS_ZERO : CLS_DENORM;
      else if (e == 8'd255)
         c = (f == 23'd0) ? CLS_INF : CLS_NAN;
      else
         c = CLS_NORMAL;
      return c;
   endfunction

   // Entry layout: {class[2:0], sign, exp[7:0], fra[22:0]}.
   function automatic logic [34:0] pack_entry(input logic s, input logic [7:0] e,
                                              input logic [22:0] f);
      logic [2:0]  c;
      logic [34:0] r;
      c = classify(e, f);
      if (FLUSH_DENORM && (c == CLS_DENORM))
         r = {CLS_ZERO, s, 8'd0, 23'd0};
      else
         r = {c, s, e, f};
      return r;
   endfunction

   logic [34:0]   mem1 [DEPTH];
   logic [34:0]   mem2 [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic [34:0]   head1;
   logic [34:0]   head2;
   logic [34:0]   new_e1;
   logic [34:0]   new_e2;
   logic [34:0]   head1_next;
   logic [34:0]   head2_next;
   logic [CW-1:0] remain;
   logic          full;
   logic          push;
   logic          pop;
   logic          drop;
   logic          load_head;

   // Handshake: an entry moves to the FPU on a cycle where valid and ready are both
   // high; valid never depends on ready, and cap_ready depends on ready but not cap_en.
   always_comb begin
      full       = (count == FULL_CNT);
      valid      = (count != '0);
      pop        = valid & ready;
      push       = cap_en & (~full | pop);
      cap_ready  = ~full | ready;
      drop       = cap_en & ~push;
      new_e1     = pack_entry(sig1, exp1, fra1);
      new_e2     = pack_entry(sig2, exp2, fra2);
      rd_next    = rd_ptr + AW'(pop);
      remain     = count - CW'(pop);
      load_head  = push | (remain != '0);
      head1_next = mem1[rd_next];
      head2_next = mem2[rd_next];
      // When nothing older survives this cycle, the entry being captured becomes head.
      if (remain == '0) begin
         head1_next = new_e1;
         head2_next = new_e2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && push) begin
         mem1[wr_ptr] <= new_e1;
         mem2[wr_ptr] <= new_e2;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         head1     <= '0;
         head2     <= '0;
         drop_cnt  <= '0;
         issue_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr    <= rd_next;
            issue_cnt <= issue_cnt + CNT_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (load_head) begin
            head1 <= head1_next;
            head2 <= head2_next;
         end
         if (drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

   assign x1     = head1[31:0];
   assign x2     = head2[31:0];
   assign class1 = head1[34:32];
   assign class2 = head2[34:32];

endmodule

// File: tb/tb_fpu_operand_feeder.sv
// Directed bench for fpu_operand_feeder: a default instance plus a flush/narrow-counter
// instance (DEPTH=2, CNT_W=2) for denormal flushing, drop saturation and issue wrap.
module tb_fpu_operand_feeder;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sig1, sig2;
   logic [7:0]  exp1, exp2;
   logic [22:0] fra1, fra2;
   logic        cap_en, ready;
   logic        cap_ready, valid;
   logic [31:0] x1, x2;
   logic [2:0]  class1, class2;
   logic [2:0]  count;
   logic [15:0] drop_cnt, issue_cnt;

   logic        cap_en_f, ready_f;
   logic        cap_ready_f, valid_f;
   logic [31:0] x1_f, x2_f;
   logic [2:0]  class1_f, class2_f;
   logic [1:0]  count_f;
   logic [1:0]  drop_f, issue_f;

   fpu_operand_feeder #(.DEPTH(DEPTH), .FLUSH_DENORM(1'b0), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .sig1(sig1), .exp1(exp1), .fra1(fra1), .sig2(sig2), .exp2(exp2), .fra2(fra2),
      .cap_en(cap_en), .cap_ready(cap_ready), .x1(x1), .x2(x2),
      .class1(class1), .class2(class2), .valid(valid), .ready(ready),
      .count(count), .drop_cnt(drop_cnt), .issue_cnt(issue_cnt)
   );

   fpu_operand_feeder #(.DEPTH(2), .FLUSH_DENORM(1'b1), .CNT_W(2)) dut_f (
      .clk(clk), .reset(reset),
      .sig1(sig1), .exp1(exp1), .fra1(fra1), .sig2(sig2), .exp2(exp2), .fra2(fra2),
      .cap_en(cap_en_f), .cap_ready(cap_ready_f), .x1(x1_f), .x2(x2_f),
      .class1(class1_f), .class2(class2_f), .valid(valid_f), .ready(ready_f),
      .count(count_f), .drop_cnt(drop_f), .issue_cnt(issue_f)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] exp_q[$];
   logic [2:0]  cls_tab [5];
   logic [7:0]  e_tab [5];
   logic [22:0] f_tab [5];
   logic [31:0] w_tab [5];
   int          n_cap, n_drop_m, cyc;
   logic        m_push, m_pop, hold_next;
   logic [63:0] prev;

   initial begin
      reset = 1'b0; cap_en = 1'b0; ready = 1'b0; cap_en_f = 1'b0; ready_f = 1'b0;
      sig1 = 1'b0; exp1 = 8'd0; fra1 = 23'd0; sig2 = 1'b0; exp2 = 8'd0; fra2 = 23'd0;

      // reset state
      tick(); tick();
      chk("rst_count", count, 0);
      chk("rst_valid", valid, 0);
      chk("rst_x", {x1, x2}, 0);
      chk("rst_class", {class1, class2}, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_issue", issue_cnt, 0);
      chk("rst_cap_ready", cap_ready, 1);
      reset = 1'b1;
      tick();

      // single capture, then one handshake
      sig1 = 1'b0; exp1 = 8'd127; fra1 = 23'd0;
      sig2 = 1'b1; exp2 = 8'd128; fra2 = 23'h400000;
      cap_en = 1'b1;
      #1;
      chk("no_same_cycle", valid, 0);
      tick();
      cap_en = 1'b0;
      chk("single_valid", valid, 1);
      chk("single_x1", x1, 32'h3F800000);
      chk("single_x2", x2, 32'hC0400000);
      chk("single_class", {class1, class2}, {3'd4, 3'd4});
      chk("single_count", count, 1);
      tick();
      chk("single_hold", x1, 32'h3F800000);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("single_pop_valid", valid, 0);
      chk("single_pop_issue", issue_cnt, 1);
      chk("single_hold_after_pop", x1, 32'h3F800000);

      // classification, streaming with ready high
      e_tab = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd100};
      f_tab = '{23'd0, 23'd5, 23'd0, 23'd1, 23'd1000000};
      w_tab = '{32'h00000000, 32'h00000005, 32'h7F800000, 32'h7F800001, 32'h320F4240};
      cls_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sig1 = 1'b0; exp1 = e_tab[i]; fra1 = f_tab[i];
         sig2 = 1'b1; exp2 = e_tab[i]; fra2 = f_tab[i];
         cap_en = 1'b1;
         tick();
         chk($sformatf("cls_class1_%0d", i), class1, cls_tab[i]);
         chk($sformatf("cls_class2_%0d", i), class2, cls_tab[i]);
         chk($sformatf("cls_x1_%0d", i), x1, w_tab[i]);
         chk($sformatf("cls_x2_%0d", i), x2, w_tab[i] | 32'h80000000);
         chk($sformatf("cls_count_%0d", i), count, 1);
      end
      cap_en = 1'b0;
      tick();
      ready = 1'b0;
      chk("cls_drained", count, 0);
      chk("cls_issue", issue_cnt, 6);

      // flushing instance: denormals become signed zero
      sig1 = 1'b1; exp1 = 8'd0; fra1 = 23'd5;
      sig2 = 1'b0; exp2 = 8'd0; fra2 = 23'd5;
      cap_en_f = 1'b1;
      tick();
      cap_en_f = 1'b0;
      chk("flush_x1", x1_f, 32'h80000000);
      chk("flush_class1", class1_f, 0);
      chk("flush_x2", x2_f, 32'h00000000);
      chk("flush_class2", class2_f, 0);
      chk("flush_count", count_f, 1);

      // flushing instance: drop saturation at 2'b11, then issue wrap
      cap_en_f = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("sat_drop_3", drop_f, 3);
      tick();
      chk("sat_drop_hold", drop_f, 3);
      chk("sat_count", count_f, 2);
      chk("sat_cap_ready", cap_ready_f, 0);
      cap_en_f = 1'b0; ready_f = 1'b1;
      tick(); tick();
      chk("wrap_drain_issue", issue_f, 2);
      chk("wrap_drain_count", count_f, 0);
      cap_en_f = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      cap_en_f = 1'b0; ready_f = 1'b0;
      chk("wrap_issue", issue_f, 1);
      chk("wrap_count", count_f, 1);
      chk("wrap_drop_unchanged", drop_f, 3);

      // overflow: six captures into a depth-4 FIFO with ready low
      sig1 = 1'b0; exp1 = 8'd1; sig2 = 1'b0; exp2 = 8'd2; fra2 = 23'd0;
      cap_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         fra1 = 23'(i);
         tick();
      end
      cap_en = 1'b0;
      chk("ovf_count", count, 4);
      chk("ovf_cap_ready", cap_ready, 0);
      chk("ovf_drop", drop_cnt, 2);
      chk("ovf_head", x1, 32'h00800000);
      ready = 1'b1;
      #1;
      chk("full_cap_ready_with_ready", cap_ready, 1);

      // full FIFO with simultaneous pop and push
      fra1 = 23'd10; cap_en = 1'b1;
      tick();
      cap_en = 1'b0;
      chk("simul_count", count, 4);
      chk("simul_drop", drop_cnt, 2);
      chk("drain_head1", x1, 32'h00800001);
      tick();
      chk("drain_head2", x1, 32'h00800002);
      tick();
      chk("drain_head3", x1, 32'h00800003);
      tick();
      chk("drain_new_last", x1, 32'h0080000A);
      chk("drain_new_count", count, 1);
      tick();
      ready = 1'b0;
      chk("drain_empty", valid, 0);
      chk("drain_issue", issue_cnt, 11);

      // backpressure: 100 captures against a random ready pattern
      n_cap = 0; n_drop_m = 0; cyc = 0;
      while ((n_cap < 100 || exp_q.size() != 0) && cyc < 3000) begin
         ready  = 1'($urandom_range(0, 1));
         cap_en = (n_cap < 100) && ($urandom_range(0, 3) != 0);
         sig1 = 1'b0; exp1 = 8'd130; fra1 = 23'(n_cap);
         sig2 = 1'b1; exp2 = 8'd3;   fra2 = 23'(1000 + n_cap);
         #1;
         hold_next = valid && !ready;
         prev   = {x1, x2};
         m_pop  = (exp_q.size() != 0) && ready;
         m_push = cap_en && ((exp_q.size() < DEPTH) || m_pop);
         if (cap_en && !m_push) n_drop_m++;
         tick();
         cyc++;
         if (m_pop) void'(exp_q.pop_front());
         if (m_push) begin
            exp_q.push_back({1'b0, 8'd130, 23'(n_cap), 1'b1, 8'd3, 23'(1000 + n_cap)});
            n_cap++;
         end
         chk("bp_valid", valid, exp_q.size() != 0);
         if (exp_q.size() != 0) chk("bp_head", {x1, x2}, exp_q[0]);
         if (hold_next) chk("bp_hold", {x1, x2}, prev);
      end
      cap_en = 1'b0; ready = 1'b0;
      chk("bp_timeout", cyc < 3000, 1);
      chk("bp_issue", issue_cnt, 111);
      chk("bp_drop", drop_cnt, 2 + n_drop_m);
      chk("bp_count", count, 0);

      // reset in the middle of a stream
      exp1 = 8'd140; fra1 = 23'd7;
      cap_en = 1'b1;
      tick(); tick(); tick();
      chk("mid_pre_count", count, 3);
      reset = 1'b0;
      tick();
      chk("mid_count", count, 0);
      chk("mid_valid", valid, 0);
      chk("mid_drop", drop_cnt, 0);
      chk("mid_issue", issue_cnt, 0);
      chk("mid_x", {x1, x2}, 0);
      chk("mid_f_count", count_f, 0);
      reset = 1'b1; cap_en = 1'b0;
      tick();
      chk("mid_post_count", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_operand_feeder.md
Name: fpu_operand_feeder

Overview:
Sits directly downstream of the operand stimulus generators (per-operand sign, exponent and fraction sources). Each capture packs the two generated fields into IEEE-754 single words x1/x2, classifies each word, and buffers the pair in a small FIFO. The FIFO front-ends the FPU unit under test through a valid/ready handshake. Drops and issues are counted for bench reporting.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
FLUSH_DENORM, 0, 1 = denormal operands are replaced by signed zero (sign kept, exp=0, fra=0) and classed ZERO.
CNT_W, 16, width of drop_cnt and issue_cnt.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low
sig1  in  1  operand 1 sign
exp1  in  8  operand 1 biased exponent
fra1  in  23  operand 1 fraction
sig2  in  1  operand 2 sign
exp2  in  8  operand 2 biased exponent
fra2  in  23  operand 2 fraction
cap_en  in  1  capture the current field values this cycle
cap_ready  out  1  a capture this cycle will be accepted
x1  out  32  head operand 1 {sig,exp,fra}
x2  out  32  head operand 2
class1  out  3  head operand 1 class
class2  out  3  head operand 2 class
valid  out  1  head entry present
ready  in  1  FPU accepts head
count  out  log2(DEPTH)+1  FIFO occupancy
drop_cnt  out  CNT_W  captures rejected because the FIFO was full
issue_cnt  out  CNT_W  handshakes completed

Behaviour:
- Reset (reset==0 at posedge): FIFO empty, count=0, valid=0, x1=x2=0, class1=class2=0, drop_cnt=0, issue_cnt=0. Reset mid-operation discards all entries, including ones being pushed or popped in that cycle.
- Class encoding, computed combinationally at capture and stored with the entry:
  - 0 ZERO: exp=0, fra=0.
  - 1 DENORM: exp=0, fra!=0.
  - 2 INF: exp=255, fra=0.
  - 3 NAN: exp=255, fra!=0.
  - 4 NORMAL: all other encodings.
- With FLUSH_DENORM=1, a denormal is stored as {sig,8'd0,23'd0} with class 0.
- Pack order: bit31 = sign, [30:23] = exp, [22:0] = fra. No rounding or arithmetic is applied.
- pop = valid & ready.
- push = cap_en & (count<DEPTH | pop). A push into a full FIFO is allowed when a pop happens in the same cycle.
- cap_ready = (count<DEPTH) | ready. Combinational from ready; no path from cap_en.
- Drop: cap_en & !push. drop_cnt increments by 1 and saturates at all-ones.
- issue_cnt increments on pop and wraps modulo 2^CNT_W.
- Show-ahead FIFO:
  - valid = (count!=0).
  - x1/x2/class1/class2 show the head entry while valid=1; they hold their last value while valid=0.
- Latency: a push into an empty FIFO appears on the outputs with valid=1 on the next cycle. A sample is never presented in the same cycle it is captured.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Simultaneous push and pop with count=1: the head advances to the new entry, valid stays 1.
- Head contents are stable while valid=1 and ready=0.
- Ordering is strict FIFO. Pointers wrap modulo DEPTH.

Test Plan:
- Reset then single capture:
  - Stimulus: sig1=0, exp1=127, fra1=0; sig2=1, exp2=128, fra2=0x400000; cap_en for one cycle; ready=0.
  - Required: next cycle valid=1, x1=0x3F800000, x2=0xC0400000, class1=class2=4, count=1.
  - Then ready=1 for one cycle: valid=0, issue_cnt=1.
- Classification:
  - Stimulus: captures of (exp,fra) = (0,0), (0,5), (255,0), (255,1), (100,1000000).
  - Required: classes 0,1,2,3,4 in order.
  - Repeat with FLUSH_DENORM=1, sig=1, (0,5): x=0x80000000, class 0.
- Overflow:
  - Stimulus: ready=0, cap_en held for 6 cycles, DEPTH=4.
  - Required: count=4, cap_ready=0, drop_cnt=2, head is the first capture.
- Full plus simultaneous pop/push:
  - Stimulus: FIFO full, ready=1 and cap_en=1 for one cycle.
  - Required: count stays 4, drop_cnt unchanged, the new sample is last to drain.
- Backpressure stability:
  - Stimulus: random ready pattern, 100 captures with fra incrementing.
  - Required: output sequence equals capture sequence, x1/x2 held stable whenever valid & !ready, issue_cnt=100.
- Reset mid-stream:
  - Stimulus: reset=0 for one cycle with count=3 and cap_en=1.
  - Required: next cycle count=0, valid=0, both counters 0.
